// File: rtl/seven_segment_display_arbiter.sv
// Round-robin arbiter sharing one seven-segment display between several image clients.
// Define BLANK_ON_IDLE_EN to blank and clear the display whenever the arbiter goes idle.
module seven_segment_display_arbiter #(
    parameter int unsigned REQUESTERS  = 4,
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned HOLD_CYCLES = 100000000
) (
    input  logic                           clock,
    input  logic                           resetN,
    input  logic [REQUESTERS-1:0]          requestValid,
    input  logic [REQUESTERS*DIGITS*4-1:0] requestData,
    input  logic [REQUESTERS*DIGITS-1:0]   requestPoint,
    output logic [REQUESTERS-1:0]          requestReady,
    output logic [REQUESTERS-1:0]          grant,
    output logic [DIGITS*4-1:0]            displayData,
    output logic [DIGITS-1:0]              displayPoint,
    output logic                           displayBlank
);

    localparam int unsigned DATA_W = DIGITS * 4;
    localparam int unsigned CNT_W  = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned IDX_W  = $clog2(REQUESTERS);
    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(REQUESTERS - 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [REQUESTERS-1:0] grant_q, grant_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DIGITS-1:0]   point_q, point_d;
    logic                blank_q, blank_d;

    logic                arb_open;
    logic                rr_found;
    logic [IDX_W-1:0]    rr_idx;
    logic [IDX_W-1:0]    rr_cand;
    logic                acc_valid;
    logic [IDX_W-1:0]    acc_idx;

    // Round-robin search over valid clients, starting at the priority pointer.
    always_comb begin
        arb_open = (state_q == IDLE) || (cnt_q == '0);
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int unsigned k = 0; k < REQUESTERS; k++) begin
            rr_cand = IDX_W'((32'(ptr_q) + k) % REQUESTERS);
            if (!rr_found && requestValid[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // During a running hold only the owner may refresh its image.
    always_comb begin
        acc_valid = 1'b0;
        acc_idx   = '0;
        if (resetN) begin
            if (arb_open) begin
                acc_valid = rr_found;
                acc_idx   = rr_idx;
            end else if (requestValid[owner_q]) begin
                acc_valid = 1'b1;
                acc_idx   = owner_q;
            end
        end
        requestReady = acc_valid ? (REQUESTERS'(1) << acc_idx) : '0;
    end

    // Next-state and display-register logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        data_d  = data_q;
        point_d = point_q;
        blank_d = blank_q;

        if (acc_valid) begin
            state_d = HOLD;
            cnt_d   = HOLD_RELOAD;
            owner_d = acc_idx;
            grant_d = REQUESTERS'(1) << acc_idx;
            data_d  = requestData[32'(acc_idx) * DATA_W +: DATA_W];
            point_d = requestPoint[32'(acc_idx) * DIGITS +: DIGITS];
            blank_d = 1'b0;
            ptr_d   = (acc_idx == LAST_IDX) ? '0 : acc_idx + IDX_W'(1);
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
`ifdef BLANK_ON_IDLE_EN
                        blank_d = 1'b1;
                        data_d  = '0;
                        point_d = '0;
`else
                        blank_d = blank_q;
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
            data_q  <= '0;
            point_q <= '0;
            blank_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            point_q <= point_d;
            blank_q <= blank_d;
        end
    end

    assign grant        = grant_q;
    assign displayData  = data_q;
    assign displayPoint = point_q;
    assign displayBlank = blank_q;

endmodule

// File: tb/tb_seven_segment_display_arbiter.sv
// Self-checking bench for seven_segment_display_arbiter: directed steps, then random traffic
// against a cycle-level reference model of owner, hold time and round-robin pointer.
module tb_seven_segment_display_arbiter;

    localparam int unsigned R    = 4;
    localparam int unsigned D    = 8;
    localparam int unsigned HOLD = 4;
    localparam int unsigned DW   = D * 4;

    logic            clock = 1'b0;
    logic            resetN;
    logic [R-1:0]    req_valid;
    logic [R*DW-1:0] req_data;
    logic [R*D-1:0]  req_point;
    logic [R-1:0]    req_ready;
    logic [R-1:0]    grant;
    logic [DW-1:0]   disp_data;
    logic [D-1:0]    disp_point;
    logic            disp_blank;

    always #5 clock = ~clock;

    seven_segment_display_arbiter #(
        .REQUESTERS (R),
        .DIGITS     (D),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clock       (clock),
        .resetN      (resetN),
        .requestValid(req_valid),
        .requestData (req_data),
        .requestPoint(req_point),
        .requestReady(req_ready),
        .grant       (grant),
        .displayData (disp_data),
        .displayPoint(disp_point),
        .displayBlank(disp_blank)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: owner (-1 = idle), cycles shown since accept, next-priority client.
    int            m_owner;
    int            m_elapsed;
    int            m_ptr;
    logic [DW-1:0] m_data;
    logic [D-1:0]  m_point;
    logic          m_blank;
    logic [R-1:0]  keep;
    logic [3:0]    seq [4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner();
        if (!resetN) return -1;
        if (m_owner >= 0 && m_elapsed < int'(HOLD) - 1)
            return req_valid[m_owner] ? m_owner : -1;
        for (int d = 0; d < int'(R); d++) begin
            int c;
            c = (m_ptr + d) % int'(R);
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic offer(input int i, input logic [DW-1:0] d, input logic [D-1:0] p);
        req_valid[i] = 1'b1;
        req_data[i*DW +: DW] = d;
        req_point[i*D +: D]  = p;
    endtask

    task automatic offer_random(input int i);
        offer(i, DW'($urandom), D'($urandom));
    endtask

    task automatic model_reset();
        m_owner = -1; m_elapsed = 0; m_ptr = 0;
        m_data = '0; m_point = '0; m_blank = 1'b1;
    endtask

    // One clock: check ready before the edge, advance the model, check outputs after it.
    task automatic tick();
        int   w;
        logic rst_at_edge;
        #1;
        w = model_winner();
        check("ready", 64'(req_ready), (w >= 0) ? (64'(1) << w) : 64'(0));
        rst_at_edge = resetN;
        @(posedge clock);
        if (!rst_at_edge) begin
            model_reset();
        end else if (w >= 0) begin
            m_owner = w; m_elapsed = 0; m_ptr = (w + 1) % int'(R);
            m_data  = req_data[w*DW +: DW];
            m_point = req_point[w*D +: D];
            m_blank = 1'b0;
        end else if (m_owner >= 0) begin
            if (m_elapsed == int'(HOLD) - 1) begin
                m_owner = -1;
`ifdef BLANK_ON_IDLE_EN
                m_blank = 1'b1; m_data = '0; m_point = '0;
`endif
            end else begin
                m_elapsed++;
            end
        end
        #1;
        check("grant", 64'(grant), (m_owner >= 0) ? (64'(1) << m_owner) : 64'(0));
        check("data", 64'(disp_data), 64'(m_data));
        check("point", 64'(disp_point), 64'(m_point));
        check("blank", 64'(disp_blank), 64'(m_blank));
        @(negedge clock);
        if (w >= 0) req_valid[w] = 1'b0;
        for (int i = 0; i < int'(R); i++)
            if (keep[i] && !req_valid[i] && m_owner != i) offer_random(i);
    endtask

    initial begin
        req_valid = '0; req_data = '0; req_point = '0; keep = '0;
        resetN = 1'b0;
        seq = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        model_reset();
        @(negedge clock);
        tick(); tick();
        check("rst_blank", 64'(disp_blank), 64'(1));
        check("rst_grant", 64'(grant), 64'(0));
        resetN = 1'b1;

        // Idle with no requests.
        repeat (20) tick();
        check("idle_data", 64'(disp_data), 64'(0));
        check("idle_blank", 64'(disp_blank), 64'(1));

        // Single client 2 request.
        offer(2, 32'h1234ABCD, 8'h01);
        #1 check("c2_ready", 64'(req_ready), 64'(4'b0100));
        tick();
        check("c2_data", 64'(disp_data), 64'(32'h1234ABCD));
        check("c2_point", 64'(disp_point), 64'(8'h01));
        check("c2_grant", 64'(grant), 64'(4'b0100));
        check("c2_blank", 64'(disp_blank), 64'(0));
        repeat (4) tick();
        check("c2_expire_grant", 64'(grant), 64'(0));
`ifdef BLANK_ON_IDLE_EN
        check("c2_expire_blank", 64'(disp_blank), 64'(1));
        check("c2_expire_data", 64'(disp_data), 64'(0));
`else
        check("c2_expire_blank", 64'(disp_blank), 64'(0));
        check("c2_expire_data", 64'(disp_data), 64'(32'h1234ABCD));
`endif

        // Clients 0,1,3 keep requesting: back-to-back rotation, 4 cycles each.
        resetN = 1'b0; tick(); resetN = 1'b1;
        keep = 4'b1011;
        offer_random(0); offer_random(1); offer_random(3);
        for (int t = 0; t < 16; t++) begin
            tick();
            check("rr_grant", 64'(grant), 64'(seq[t/4]));
        end
        keep = '0;
        resetN = 1'b0; req_valid = '0; tick(); resetN = 1'b1;

        // Owner refresh at counter 2 defers pending client 0.
        offer_random(1);
        tick(); tick();
        offer(0, 32'hCAFE0000, 8'h80);
        offer(1, 32'h00000042, 8'h00);
        #1 check("refresh_ready", 64'(req_ready), 64'(4'b0010));
        tick();
        check("refresh_data", 64'(disp_data), 64'(32'h00000042));
        for (int t = 0; t < 3; t++) begin
            tick();
            check("refresh_hold", 64'(grant), 64'(4'b0010));
        end
        tick();
        check("refresh_next", 64'(grant), 64'(4'b0001));
        check("refresh_next_data", 64'(disp_data), 64'(32'hCAFE0000));

        // Hold expires with nobody waiting.
        repeat (4) tick();
        check("idle_grant", 64'(grant), 64'(0));
`ifdef BLANK_ON_IDLE_EN
        check("idle_blank2", 64'(disp_blank), 64'(1));
        check("idle_data2", 64'(disp_data), 64'(0));
`else
        check("idle_blank2", 64'(disp_blank), 64'(0));
        check("idle_data2", 64'(disp_data), 64'(32'hCAFE0000));
`endif

        // Reset during a hold with others pending.
        offer_random(1); offer_random(2);
        tick(); tick();
        resetN = 1'b0;
        offer_random(0);
        #1 check("rst_ready", 64'(req_ready), 64'(0));
        tick();
        check("midrst_grant", 64'(grant), 64'(0));
        check("midrst_blank", 64'(disp_blank), 64'(1));
        check("midrst_data", 64'(disp_data), 64'(0));
        resetN = 1'b1;
        tick();
        check("postrst_grant", 64'(grant), 64'(4'b0001));

        // Random traffic with occasional resets.
        repeat (3000) begin
            for (int i = 0; i < int'(R); i++)
                if (!req_valid[i] && $urandom_range(3) == 0) offer_random(i);
            resetN = ($urandom_range(149) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
